// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   uart_tx_state_t : frame FSM states
//   TICKS_PER_BIT   : oversampling ticks per start/data bit
//   cnt_width()     : counter width helper with a lower bound
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int unsigned TICKS_PER_BIT = 16;

  // Bits needed to count 0..count-1, never less than min_w.
  function automatic int unsigned cnt_width(input int unsigned count,
                                            input int unsigned min_w);
    int unsigned w;
    w = (count > 1) ? $clog2(count) : 1;
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator.
//   clk   : clock
//   reset : synchronous active-high reset
//   clr   : forces the counter back to 0 (frame-aligned restart)
//   tick  : high for one clk when the counter sits at DVSR-1
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DVSR = 326
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DVSR, 1);
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] count;

  // Free-running 0..DVSR-1, wrapped by compare.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains a first-word-fall-through FIFO onto a serial line as
// start / DATA_SIZE data bits (LSB first) / stop frames.
//   clk          : clock
//   reset        : synchronous active-high reset
//   fifo_empty   : FIFO empty flag
//   fifo_rdata   : FIFO head word, valid while fifo_empty=0
//   fifo_rd      : pop strobe, one clk per byte (decoded from state)
//   tx           : serial line, idles high, registered
//   tx_busy      : high from the clk after a pop until the frame ends
//   tx_done_tick : one-clk pulse in the last clk of the stop bit
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DVSR      = 326,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rdata,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int unsigned S_W = cnt_width(SB_TICK, 4);
  localparam int unsigned N_W = cnt_width(DATA_SIZE, 1);

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(TICKS_PER_BIT - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_SIZE - 1);

  uart_tx_state_t state, state_next;
  logic [S_W-1:0]       s, s_next;
  logic [N_W-1:0]       n, n_next;
  logic [DATA_SIZE-1:0] b, b_next;
  logic                 tx_next;
  logic                 busy_next;
  logic                 pop;
  logic                 done;
  logic                 tick;

  // Baud counter restarts on the pop so every frame is bit-exact.
  uart_baud_gen #(
    .DVSR (DVSR)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (pop),
    .tick  (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      s       <= s_next;
      n       <= n_next;
      b       <= b_next;
      tx      <= tx_next;
      tx_busy <= busy_next;
    end
  end

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    pop        = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          b_next     = fifo_rdata;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_BIT_LAST) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + N_W'(1);
            end
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_STOP_LAST) begin
            s_next     = '0;
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered, so tx lands one clk
    // after the decision and the start bit begins the clk after the pop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
  end

  // Strobes are suppressed while reset is held so no byte is lost.
  assign fifo_rd      = pop  & ~reset;
  assign tx_done_tick = done & ~reset;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain with DVSR=4: bit = 64 clk, frame = 640 clk.
// Drives a queue-based FWFT FIFO model; a line monitor checks each frame
// cycle by cycle against the byte expected at the scoreboard head.
module tb_uart_tx_fifo_drain;

  localparam int unsigned DS        = 8;
  localparam int unsigned DV        = 4;
  localparam int unsigned SBT       = 16;
  localparam int          BIT_CLK   = 64;
  localparam int          FRAME_CLK = 640;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  logic       wr_en      = 1'b0;
  logic [7:0] wr_data    = 8'h00;
  logic       hold_empty = 1'b0;

  logic [7:0] fq[$];
  logic [7:0] sb[$];
  int         gap_q[$];

  int total = 0;
  int bad   = 0;
  int rd_pulses = 0;
  int done_cnt  = 0;
  int frames    = 0;

  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  int         idle_run   = 0;
  int         frame_err  = 0;
  logic [7:0] exp_byte   = 8'h00;
  logic [7:0] dec        = 8'h00;
  logic       prev_rd    = 1'b0;

  uart_tx_fifo_drain #(
    .DATA_SIZE (DS),
    .DVSR      (DV),
    .SB_TICK   (SBT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Depth-8 first-word-fall-through FIFO model.
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_pulses++;
      if (fq.size() != 0) fq.delete(0);
    end
    if (wr_en && fq.size() < 8) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0) || hold_empty;
    fifo_rdata <= (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Line monitor / scoreboard consumer.
  always @(negedge clk) begin
    int idx;
    logic exp_bit;
    if (tx_done_tick) done_cnt++;
    if (fifo_rd && fifo_empty) check("rd_when_empty", 32'(fifo_rd), 32'd0);
    if (reset) begin
      if (mon_active && sb.size() != 0) sb.delete(0);
      mon_active = 1'b0;
      idle_run   = 0;
    end else begin
      if (!mon_active) begin
        if (tx_done_tick) check("done_stray", 32'(tx_done_tick), 32'd0);
        if (tx === 1'b0) begin
          check("pop_before_start", 32'(prev_rd), 32'd1);
          check("frame_expected", 32'(sb.size() != 0), 32'd1);
          exp_byte   = (sb.size() != 0) ? sb[0] : 8'h00;
          gap_q.push_back(idle_run);
          mon_active = 1'b1;
          mon_cnt    = 0;
          frame_err  = 0;
          dec        = 8'h00;
        end else begin
          idle_run++;
        end
      end
      if (mon_active) begin
        idx = mon_cnt / BIT_CLK;
        if (idx == 0)      exp_bit = 1'b0;
        else if (idx == 9) exp_bit = 1'b1;
        else               exp_bit = exp_byte[idx-1];
        if (tx !== exp_bit || tx_busy !== 1'b1 || fifo_rd !== 1'b0) frame_err++;
        if (mon_cnt != FRAME_CLK - 1 && tx_done_tick) frame_err++;
        if ((mon_cnt % BIT_CLK) == BIT_CLK / 2 && idx >= 1 && idx <= 8) dec[idx-1] = tx;
        if (mon_cnt == FRAME_CLK - 1) begin
          check("done_tick", 32'(tx_done_tick), 32'd1);
          check("rx_byte", 32'(dec), 32'(exp_byte));
          check("frame_shape", 32'(frame_err), 32'd0);
          if (sb.size() != 0) sb.delete(0);
          frames++;
          mon_active = 1'b0;
          idle_run   = 0;
        end else begin
          mon_cnt++;
        end
      end
    end
    prev_rd = fifo_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    sb.push_back(v);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames < target && c < budget) begin
      tick();
      c++;
    end
    check("wait_frames", 32'(frames >= target), 32'd1);
  endtask

  task automatic wait_mid_frame(input int cnt, input int budget);
    int c = 0;
    while (!(mon_active && mon_cnt >= cnt) && c < budget) begin
      tick();
      c++;
    end
    check("wait_mid_frame", 32'(mon_active && mon_cnt >= cnt), 32'd1);
  endtask

  initial begin
    int base_rd;
    int base_done;
    int f0;

    // Reset held 2 clk with the FIFO empty.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_rd", 32'(fifo_rd), 32'd0);

    // Empty FIFO: line stays idle.
    for (int i = 0; i < 1000; i++) begin
      tick();
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);
      check("idle_rd", 32'(fifo_rd), 32'd0);
    end

    // Single byte 8'h6C.
    base_rd = rd_pulses; base_done = done_cnt; f0 = frames;
    write_byte(8'h6C);
    wait_frames(f0 + 1, 800);
    check("t2_rd_count", 32'(rd_pulses - base_rd), 32'd1);
    check("t2_done_count", 32'(done_cnt - base_done), 32'd1);
    tick();
    check("t2_busy_after", 32'(tx_busy), 32'd0);
    check("t2_tx_after", 32'(tx), 32'd1);

    // Three back-to-back bytes.
    repeat (5) tick();
    gap_q.delete();
    base_rd = rd_pulses; base_done = done_cnt; f0 = frames;
    write_byte(8'h6C);
    write_byte(8'hAF);
    write_byte(8'h64);
    wait_frames(f0 + 3, 2200);
    check("t3_rd_count", 32'(rd_pulses - base_rd), 32'd3);
    check("t3_done_count", 32'(done_cnt - base_done), 32'd3);
    check("t3_frames_seen", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      check("t3_gap1", 32'(gap_q[1] <= 1), 32'd1);
      check("t3_gap2", 32'(gap_q[2] <= 1), 32'd1);
    end

    // Fill to full while held empty, then drain.
    repeat (5) tick();
    hold_empty = 1'b1;
    tick();
    base_rd = rd_pulses; base_done = done_cnt; f0 = frames;
    for (int i = 0; i < 8; i++) write_byte(8'($urandom_range(255, 0)));
    check("t4_no_pop_while_held", 32'(rd_pulses - base_rd), 32'd0);
    hold_empty = 1'b0;
    wait_frames(f0 + 8, 6000);
    check("t4_rd_count", 32'(rd_pulses - base_rd), 32'd8);
    check("t4_done_count", 32'(done_cnt - base_done), 32'd8);
    check("t4_empty", 32'(fifo_empty), 32'd1);
    for (int i = 0; i < 200; i++) begin
      tick();
      check("t4_idle_tx", 32'(tx), 32'd1);
    end
    check("t4_no_extra_frame", 32'(frames - f0), 32'd8);

    // Reset during data bit 3 of 8'hAF; next byte must go out whole.
    f0 = frames;
    write_byte(8'hAF);
    write_byte(8'h11);
    wait_mid_frame(4 * BIT_CLK + 24, 800);
    base_done = done_cnt;
    reset = 1'b1;
    tick();
    check("t5_tx_after_rst", 32'(tx), 32'd1);
    check("t5_busy_after_rst", 32'(tx_busy), 32'd0);
    check("t5_rd_in_rst", 32'(fifo_rd), 32'd0);
    reset = 1'b0;
    wait_frames(f0 + 1, 1400);
    check("t5_done_count", 32'(done_cnt - base_done), 32'd1);
    check("t5_sb_drained", 32'(sb.size()), 32'd0);

    // fifo_empty toggling mid-frame must not cause an extra pop.
    repeat (5) tick();
    base_rd = rd_pulses; f0 = frames;
    write_byte(8'h5A);
    wait_mid_frame(100, 200);
    for (int k = 0; k < 3; k++) begin
      hold_empty = 1'b1;
      repeat (10) tick();
      hold_empty = 1'b0;
      repeat (10) tick();
    end
    write_byte(8'hC3);
    repeat (20) tick();
    check("t6_rd_mid", 32'(rd_pulses - base_rd), 32'd1);
    wait_frames(f0 + 1, 800);
    check("t6_rd_at_end", 32'(rd_pulses - base_rd), 32'd1);
    wait_frames(f0 + 2, 800);
    check("t6_rd_final", 32'(rd_pulses - base_rd), 32'd2);
    check("t6_gap", 32'(gap_q[gap_q.size()-1] <= 1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
